// File: rtl/bcd_to_bin.sv
// rtl/bcd_to_bin.sv - sequential packed-BCD to binary converter, one digit per clock
module bcd_to_bin #(
    parameter int DIGITS = 4,
    parameter int OUT_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   bcd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_W-1:0]      bin,
    output logic                  err
);

    localparam int CNT_W = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [4*DIGITS-1:0] sreg;
    logic [OUT_W-1:0]    acc;
    logic [CNT_W-1:0]    cnt;
    logic                err_flag;

    logic [3:0]          nib;
    logic [OUT_W-1:0]    acc_next;
    logic                err_next;
    logic                last_digit;

    // The digit being folded in is always the top nibble of the shift register.
    assign nib = sreg[4*DIGITS-1 -: 4];

    // acc*10 built from two shifts so no multiplier is needed; wraps at OUT_W.
    assign acc_next = (acc << 3) + (acc << 1) + OUT_W'(nib);

    // The error flag is sticky; the last digit's check is folded in so DONE sees it.
    assign err_next = err_flag | (nib > 4'd9);

    assign last_digit = (cnt == CNT_W'(DIGITS - 1));

    // Acceptance depends only on state so upstream never sees a combinational loop.
    assign in_ready = (state == IDLE);

    // Control FSM with datapath: capture in IDLE, one digit per edge in CONV, hold in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sreg      <= '0;
            acc       <= '0;
            cnt       <= '0;
            err_flag  <= 1'b0;
            out_valid <= 1'b0;
            bin       <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sreg     <= bcd;
                        acc      <= '0;
                        cnt      <= '0;
                        err_flag <= 1'b0;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    acc      <= acc_next;
                    sreg     <= sreg << 4;
                    cnt      <= cnt + 1'b1;
                    err_flag <= err_next;
                    if (last_digit) begin
                        bin       <= err_next ? '0 : acc_next;
                        err       <= err_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin.sv
// tb/tb_bcd_to_bin.sv - scoreboard testbench for bcd_to_bin
module tb_bcd_to_bin;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] bcd;
    logic        out_valid;
    logic        out_ready;
    logic [13:0] bin;
    logic        err;

    int checks;
    int failures;

    typedef struct packed {
        logic [13:0] bin;
        logic        err;
    } exp_t;

    exp_t sb[$];

    bcd_to_bin #(.DIGITS(4), .OUT_W(14)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd       (bcd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin       (bin),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [15:0] w);
        exp_t e;
        int   v;
        int   d;
        e.err = 1'b0;
        v = 0;
        for (int i = 3; i >= 0; i--) begin
            d = int'((w >> (4 * i)) & 16'h000F);
            if (d > 9) e.err = 1'b1;
            v = v * 10 + d;
        end
        e.bin = e.err ? 14'd0 : v[13:0];
        return e;
    endfunction

    task automatic accept(input logic [15:0] w);
        int n;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL accept_ready got=%b exp=1", in_ready);
        end
        bcd = w;
        in_valid = 1'b1;
        sb.push_back(model(w));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        bcd = 16'($urandom);
    endtask

    task automatic collect(input int hold);
        int   lat;
        exp_t e;
        logic [13:0] bin_first;
        lat = 0;
        while (lat < 30) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) break;
        end
        checks++;
        if (lat !== 4 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL latency got=%0d valid=%b exp=4", lat, out_valid);
        end
        e = sb.pop_front();
        checks++;
        if (bin !== e.bin) begin
            failures++;
            $display("FAIL bin got=%0d exp=%0d", bin, e.bin);
        end
        checks++;
        if (err !== e.err) begin
            failures++;
            $display("FAIL err got=%b exp=%b", err, e.err);
        end
        bin_first = bin;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            bcd = 16'h9999;
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || bin !== bin_first || err !== e.err || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL hold_stable valid=%b bin=%0d err=%b ready=%b exp 1/%0d/%b/0",
                         out_valid, bin, err, in_ready, bin_first, e.err);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL handshake valid=%b ready=%b exp 0/1", out_valid, in_ready);
        end
        checks++;
        if (bin !== bin_first || err !== e.err) begin
            failures++;
            $display("FAIL keep_after_take bin=%0d err=%b exp %0d/%b", bin, err, bin_first, e.err);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        bcd = 16'h1234;
        #12;
        checks++;
        if (out_valid !== 1'b0 || bin !== 14'd0 || err !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_state valid=%b bin=%0d err=%b ready=%b exp 0/0/0/1",
                     out_valid, bin, err, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL post_release ready=%b valid=%b exp 1/0", in_ready, out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_convert;
        accept(16'h1234); collect(0);
        accept(16'h9999); collect(0);
        accept(16'h0000); collect(0);
        accept(16'h0905); collect(1);
    endtask

    task automatic test_error;
        accept(16'h12A4); collect(0);
        accept(16'h0007); collect(0);
        accept(16'hF000); collect(0);
        accept(16'h999A); collect(0);
    endtask

    task automatic test_backpressure;
        accept(16'h0420); collect(5);
    endtask

    task automatic test_back_to_back;
        logic [15:0] words [3];
        exp_t e;
        int k;
        int got;
        int last;
        words[0] = 16'h0001;
        words[1] = 16'h4321;
        words[2] = 16'h8765;
        k = 0;
        got = 0;
        last = -1;
        @(negedge clk);
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 60 && got < 3; c++) begin
            if (c > 0) @(negedge clk);
            if (out_valid) begin
                e = sb.pop_front();
                checks++;
                if (bin !== e.bin || err !== e.err) begin
                    failures++;
                    $display("FAIL b2b_result bin=%0d err=%b exp %0d/%b", bin, err, e.bin, e.err);
                end
                got++;
            end
            if (in_ready && k < 3) begin
                bcd = words[k];
                sb.push_back(model(words[k]));
                if (last >= 0) begin
                    checks++;
                    if (c - last !== 6) begin
                        failures++;
                        $display("FAIL b2b_spacing got=%0d exp=6", c - last);
                    end
                end
                last = c;
                k++;
            end else if (in_ready) begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (got !== 3) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=3", got);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_abort;
        @(negedge clk);
        bcd = 16'h1234;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || bin !== 14'd0 || err !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL async_abort valid=%b bin=%0d err=%b ready=%b exp 0/0/0/1",
                     out_valid, bin, err, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL no_result_after_abort valid=%b ready=%b exp 0/1", out_valid, in_ready);
            end
        end
        accept(16'h0050); collect(0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_convert();
        test_error();
        test_backpressure();
        test_back_to_back();
        test_reset_abort();
        checks++;
        if (sb.size() !== 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
